// File: rtl/y86_pkg.sv
// ============================================================================
// Module : y86_pkg
// Brief  : Shared Y86-64 types and constants for the decode/write-back stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package y86_pkg;

   localparam int WORD_W = 64;

   // Numbering follows the standard Y86-64 encoding (9 = ret, 10 = pushq, 11 = popq).
   typedef enum logic [3:0] {
      I_HALT  = 4'h0,
      I_NOP   = 4'h1,
      I_CMOV  = 4'h2,
      I_IRMOV = 4'h3,
      I_RMMOV = 4'h4,
      I_MRMOV = 4'h5,
      I_OPQ   = 4'h6,
      I_JXX   = 4'h7,
      I_CALL  = 4'h8,
      I_RET   = 4'h9,
      I_PUSH  = 4'hA,
      I_POP   = 4'hB
   } icode_e;

   localparam logic [3:0] R_RAX  = 4'd0;
   localparam logic [3:0] R_RCX  = 4'd1;
   localparam logic [3:0] R_RDX  = 4'd2;
   localparam logic [3:0] R_RBX  = 4'd3;
   localparam logic [3:0] R_RSP  = 4'd4;
   localparam logic [3:0] R_RBP  = 4'd5;
   localparam logic [3:0] R_RSI  = 4'd6;
   localparam logic [3:0] R_RDI  = 4'd7;
   localparam logic [3:0] R_R8   = 4'd8;
   localparam logic [3:0] R_R9   = 4'd9;
   localparam logic [3:0] R_R10  = 4'd10;
   localparam logic [3:0] R_R11  = 4'd11;
   localparam logic [3:0] R_R12  = 4'd12;
   localparam logic [3:0] R_R13  = 4'd13;
   localparam logic [3:0] R_R14  = 4'd14;
   localparam logic [3:0] R_NONE = 4'hF;

   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      logic [3:0] src_a;
      logic [3:0] src_b;
      logic [3:0] dst_e;
      logic [3:0] dst_m;
   } dec_ids_t;

endpackage

`default_nettype wire

// File: rtl/regfile_2r2w.sv
// ============================================================================
// Module : regfile_2r2w
// Brief  : Register file, two async read ports + debug port, two sync write
//          ports (port M wins on collision), synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_2r2w #(
   parameter int NREGS = 15,
   parameter int W     = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   ra_i,
   input  logic [3:0]   rb_i,
   input  logic [3:0]   dbg_i,
   output logic [W-1:0] rda_o,
   output logic [W-1:0] rdb_o,
   output logic [W-1:0] dbg_o,
   input  logic         we_i,
   input  logic [3:0]   wae_i,
   input  logic [W-1:0] wde_i,
   input  logic [3:0]   wam_i,
   input  logic [W-1:0] wdm_i
);

   logic [W-1:0] regs_q [NREGS];

   // IDs at or above NREGS (notably 4'hF) have no storage and read as zero.
   assign rda_o = (int'(ra_i)  < NREGS) ? regs_q[ra_i]  : '0;
   assign rdb_o = (int'(rb_i)  < NREGS) ? regs_q[rb_i]  : '0;
   assign dbg_o = (int'(dbg_i) < NREGS) ? regs_q[dbg_i] : '0;

   // Port M is written after port E so it takes the later non-blocking update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         if (int'(wae_i) < NREGS) begin
            regs_q[wae_i] <= wde_i;
         end
         if (int'(wam_i) < NREGS) begin
            regs_q[wam_i] <= wdm_i;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/decode_writeback.sv
// ============================================================================
// Module : decode_writeback
// Brief  : Y86-64 SEQ decode (register ID generation, operand read) and
//          write-back of valE/valM into the register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_writeback
   import y86_pkg::*;
#(
   parameter int         NREGS  = 15,
   parameter logic [3:0] RSP_ID = 4'd4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        icode,
   input  logic [3:0]        rA,
   input  logic [3:0]        rB,
   input  logic              cnd,
   input  logic              wb_en,
   input  logic [WORD_W-1:0] valE,
   input  logic [WORD_W-1:0] valM,
   output logic [3:0]        srcA,
   output logic [3:0]        srcB,
   output logic [3:0]        dstE,
   output logic [3:0]        dstM,
   output logic [WORD_W-1:0] valA,
   output logic [WORD_W-1:0] valB,
   input  logic [3:0]        dbg_sel,
   output logic [WORD_W-1:0] dbg_val
);

   dec_ids_t ids;
   icode_e   icode_cast;

   assign icode_cast = icode_e'(icode);

   always_comb begin
      ids.src_a = R_NONE;
      ids.src_b = R_NONE;
      ids.dst_e = R_NONE;
      ids.dst_m = R_NONE;
      case (icode_cast)
         I_CMOV: begin
            ids.src_a = rA;
            ids.dst_e = cnd ? rB : R_NONE;
         end
         I_IRMOV: begin
            ids.dst_e = rB;
         end
         I_RMMOV: begin
            ids.src_a = rA;
            ids.src_b = rB;
         end
         I_MRMOV: begin
            ids.src_b = rB;
            ids.dst_m = rA;
         end
         I_OPQ: begin
            ids.src_a = rA;
            ids.src_b = rB;
            ids.dst_e = rB;
         end
         I_CALL: begin
            ids.src_b = RSP_ID;
            ids.dst_e = RSP_ID;
         end
         I_RET: begin
            ids.src_a = RSP_ID;
            ids.src_b = RSP_ID;
            ids.dst_e = RSP_ID;
         end
         I_PUSH: begin
            ids.src_a = rA;
            ids.src_b = RSP_ID;
            ids.dst_e = RSP_ID;
         end
         I_POP: begin
            ids.src_a = RSP_ID;
            ids.src_b = RSP_ID;
            ids.dst_e = RSP_ID;
            ids.dst_m = rA;
         end
         default: begin
            ids.src_a = R_NONE;
         end
      endcase
   end

   assign srcA = ids.src_a;
   assign srcB = ids.src_b;
   assign dstE = ids.dst_e;
   assign dstM = ids.dst_m;

   regfile_2r2w #(
      .NREGS (NREGS),
      .W     (WORD_W)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .ra_i  (ids.src_a),
      .rb_i  (ids.src_b),
      .dbg_i (dbg_sel),
      .rda_o (valA),
      .rdb_o (valB),
      .dbg_o (dbg_val),
      .we_i  (wb_en),
      .wae_i (ids.dst_e),
      .wde_i (valE),
      .wam_i (ids.dst_m),
      .wdm_i (valM)
   );

endmodule

`default_nettype wire

// File: tb/tb_decode_writeback.sv
// ============================================================================
// Module : tb_decode_writeback
// Brief  : Self-checking bench for decode_writeback: directed sequences,
//          decode table, randomized traffic against a reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_writeback;

   logic        clk;
   logic        rst;
   logic [3:0]  icode, rA, rB, dbg_sel;
   logic        cnd, wb_en;
   logic [63:0] valE, valM;
   logic [3:0]  srcA, srcB, dstE, dstM;
   logic [63:0] valA, valB, dbg_val;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] m [15];

   decode_writeback dut (
      .clk     (clk),
      .rst     (rst),
      .icode   (icode),
      .rA      (rA),
      .rB      (rB),
      .cnd     (cnd),
      .wb_en   (wb_en),
      .valE    (valE),
      .valM    (valM),
      .srcA    (srcA),
      .srcB    (srcB),
      .dstE    (dstE),
      .dstM    (dstM),
      .valA    (valA),
      .valB    (valB),
      .dbg_sel (dbg_sel),
      .dbg_val (dbg_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] ic;
      logic       c;
      logic [3:0] sa, sb, de, dm;
   } dvec_t;

   dvec_t tbl[17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference decode: set-membership form of the decode rules.
   function automatic logic [15:0] mdec(input logic [3:0] ic, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic c);
      logic [3:0] sa, sb, de, dm;
      sa = (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) ? ra :
           (ic inside {4'd9, 4'd11}) ? 4'd4 : 4'hF;
      sb = (ic inside {4'd4, 4'd5, 4'd6}) ? rb :
           (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) ? 4'd4 : 4'hF;
      de = ((ic inside {4'd3, 4'd6}) || (ic == 4'd2 && c)) ? rb :
           (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) ? 4'd4 : 4'hF;
      dm = (ic inside {4'd5, 4'd11}) ? ra : 4'hF;
      return {sa, sb, de, dm};
   endfunction

   function automatic logic [63:0] mrd(input logic [3:0] id);
      return (id == 4'hF) ? 64'd0 : m[id];
   endfunction

   task automatic tick();
      logic [15:0] d;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 15; i++) m[i] = 64'd0;
      end else if (wb_en) begin
         d = mdec(icode, rA, rB, cnd);
         if (d[7:4] != 4'hF) m[d[7:4]] = valE;
         if (d[3:0] != 4'hF) m[d[3:0]] = valM;
      end
      #1;
   endtask

   task automatic peek(input logic [3:0] sel, input logic [63:0] exp, input string name);
      @(negedge clk);
      wb_en   = 1'b0;
      dbg_sel = sel;
      #2;
      chk(name, dbg_val, exp);
   endtask

   initial begin
      logic [15:0] d;
      logic [3:0]  s;

      tbl[0]  = '{4'd0,  1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
      tbl[1]  = '{4'd1,  1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
      tbl[2]  = '{4'd2,  1'b1, 4'd1, 4'hF, 4'd2, 4'hF};
      tbl[3]  = '{4'd2,  1'b0, 4'd1, 4'hF, 4'hF, 4'hF};
      tbl[4]  = '{4'd3,  1'b1, 4'hF, 4'hF, 4'd2, 4'hF};
      tbl[5]  = '{4'd4,  1'b1, 4'd1, 4'd2, 4'hF, 4'hF};
      tbl[6]  = '{4'd5,  1'b1, 4'hF, 4'd2, 4'hF, 4'd1};
      tbl[7]  = '{4'd6,  1'b1, 4'd1, 4'd2, 4'd2, 4'hF};
      tbl[8]  = '{4'd7,  1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
      tbl[9]  = '{4'd8,  1'b1, 4'hF, 4'd4, 4'd4, 4'hF};
      tbl[10] = '{4'd9,  1'b1, 4'd4, 4'd4, 4'd4, 4'hF};
      tbl[11] = '{4'd10, 1'b1, 4'd1, 4'd4, 4'd4, 4'hF};
      tbl[12] = '{4'd11, 1'b1, 4'd4, 4'd4, 4'd4, 4'd1};
      tbl[13] = '{4'd12, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
      tbl[14] = '{4'd13, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
      tbl[15] = '{4'd14, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
      tbl[16] = '{4'd15, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};

      rst = 1'b1; icode = 4'd1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
      wb_en = 1'b0; valE = '0; valM = '0; dbg_sel = 4'd0;
      tick();
      rst = 1'b0;

      for (int i = 0; i < 16; i++) peek(4'(i), 64'd0, "reset dbg");

      // irmovq then read-after-write: old value same cycle, new value next cycle
      tick();
      icode = 4'd3; rA = 4'hF; rB = 4'd0; valE = 64'd5; wb_en = 1'b1;
      #2;
      chk("irmov dstE", {60'd0, dstE}, 64'd0);
      chk("irmov valB", valB, 64'd0);
      tick();
      icode = 4'd6; rA = 4'd0; rB = 4'd0; valE = 64'd7; wb_en = 1'b1;
      #2;
      chk("opq valA old", valA, 64'd5);
      chk("opq valB old", valB, 64'd5);
      tick();
      wb_en = 1'b0;
      #2;
      chk("opq valA new", valA, 64'd7);

      // cmovXX gated by cnd
      tick();
      icode = 4'd2; rA = 4'd1; rB = 4'd2; valE = 64'hD; cnd = 1'b0; wb_en = 1'b1;
      #2;
      chk("cmov0 dstE", {60'd0, dstE}, 64'hF);
      chk("cmov0 srcA", {60'd0, srcA}, 64'd1);
      tick();
      peek(4'd2, 64'd0, "cmov0 reg2");
      tick();
      cnd = 1'b1; wb_en = 1'b1;
      #2;
      chk("cmov1 dstE", {60'd0, dstE}, 64'd2);
      tick();
      peek(4'd2, 64'hD, "cmov1 reg2");

      // popq %rsp: M port wins over E port
      tick();
      icode = 4'd3; rB = 4'd4; valE = 64'h3F8; cnd = 1'b0; wb_en = 1'b1;
      tick();
      icode = 4'd11; rA = 4'd4; rB = 4'hF; valE = 64'h400; valM = 64'h1234; wb_en = 1'b1;
      #2;
      chk("pop dstE", {60'd0, dstE}, 64'd4);
      chk("pop dstM", {60'd0, dstM}, 64'd4);
      chk("pop valA", valA, 64'h3F8);
      chk("pop valB", valB, 64'h3F8);
      tick();
      peek(4'd4, 64'h1234, "pop rsp M wins");
      tick();
      icode = 4'd11; rA = 4'd9; valE = 64'h400; valM = 64'h5555; wb_en = 1'b1;
      tick();
      peek(4'd9, 64'h5555, "pop r9 valM");
      peek(4'd4, 64'h400, "pop r9 rsp valE");

      // wb_en low blocks write; reset beats a concurrent write
      tick();
      icode = 4'd6; rA = 4'd0; rB = 4'd3; valE = 64'hFF; wb_en = 1'b0;
      tick();
      peek(4'd3, 64'd0, "wb_en0 reg3");
      tick();
      icode = 4'd3; rB = 4'd8; valE = 64'hAA; wb_en = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0;
      peek(4'd8, 64'd0, "rst vs write reg8");
      peek(4'd4, 64'd0, "rst clears reg4");
      peek(4'd0, 64'd0, "rst clears reg0");

      // decode table
      tick();
      for (int i = 0; i < 17; i++) begin
         icode = tbl[i].ic; rA = 4'd1; rB = 4'd2; cnd = tbl[i].c; wb_en = 1'b0;
         #2;
         chk($sformatf("dec ic%0d srcA", tbl[i].ic), {60'd0, srcA}, {60'd0, tbl[i].sa});
         chk($sformatf("dec ic%0d srcB", tbl[i].ic), {60'd0, srcB}, {60'd0, tbl[i].sb});
         chk($sformatf("dec ic%0d dstE", tbl[i].ic), {60'd0, dstE}, {60'd0, tbl[i].de});
         chk($sformatf("dec ic%0d dstM", tbl[i].ic), {60'd0, dstM}, {60'd0, tbl[i].dm});
         tick();
      end

      // randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         icode   = 4'($urandom_range(0, 15));
         rA      = 4'($urandom_range(0, 15));
         rB      = 4'($urandom_range(0, 15));
         cnd     = 1'($urandom_range(0, 1));
         wb_en   = ($urandom_range(0, 7) != 0);
         rst     = ($urandom_range(0, 39) == 0);
         valE    = {$urandom, $urandom};
         valM    = {$urandom, $urandom};
         dbg_sel = 4'($urandom_range(0, 15));
         #2;
         d = mdec(icode, rA, rB, cnd);
         chk("rnd srcA", {60'd0, srcA}, {60'd0, d[15:12]});
         chk("rnd srcB", {60'd0, srcB}, {60'd0, d[11:8]});
         chk("rnd dstE", {60'd0, dstE}, {60'd0, d[7:4]});
         chk("rnd dstM", {60'd0, dstM}, {60'd0, d[3:0]});
         chk("rnd valA", valA, mrd(d[15:12]));
         chk("rnd valB", valB, mrd(d[11:8]));
         chk("rnd dbg", dbg_val, mrd(dbg_sel));
         tick();
      end
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         s = 4'(i);
         peek(s, mrd(s), "final sweep");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
